// File: rtl/hit_event_encoder_pkg.sv
// Shared types and helpers for the obstacle-hit encoder (package hit_pkg).
// Holds the obstacle codes, the encoder state type and a lowest-set-bit encoder.
package hit_pkg;

  localparam int NUM_OBST = 3;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    OBST1 = 2'b01,
    OBST2 = 2'b10,
    OBST3 = 2'b11
  } obst_code_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } enc_state_t;

  // Obstacle i+1 wins over higher indices when several are pending.
  function automatic obst_code_t lowest_code(input logic [NUM_OBST-1:0] mask);
    logic [1:0] v;
    v = 2'b00;
    for (int i = NUM_OBST - 1; i >= 0; i--) begin
      if (mask[i]) v = 2'(i + 1);
    end
    return obst_code_t'(v);
  endfunction

endpackage

// File: rtl/hit_event_encoder_cooldown_timer.sv
// Per-obstacle cooldown counter: loads on an accepted snapshot, counts down one
// per frame tick and flags when it has reached zero.
module hit_cooldown_timer #(
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_load,
  input  logic i_tick,
  output logic o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(COOLDOWN_FRAMES);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hit_event_encoder.sv
// Turns per-pixel collision flags into single-cycle obstacle hit codes with
// per-frame latching, cooldown and valid/ready serialisation. Option: HIT_SOUND_EN.
module hit_event_encoder
  import hit_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 4
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                game_enable,
  input  logic [NUM_OBST-1:0] collision,
  input  logic                event_ready,
  output logic [1:0]          obstacle_num,
  output logic                event_valid,
  output logic [7:0]          total_hits,
  output logic [3:0]          merged_hits,
  output logic                sound_trigger
);

  enc_state_t          r_state;
  obst_code_t          r_code;
  logic                r_valid;
  logic [NUM_OBST-1:0] r_latch;
  logic [NUM_OBST-1:0] r_pending;
  logic [7:0]          r_total;
  logic [3:0]          r_merged;

  logic [NUM_OBST-1:0] w_cd_zero;
  logic [NUM_OBST-1:0] w_accept_mask;
  logic [NUM_OBST-1:0] w_hit_now;
  logic [NUM_OBST-1:0] w_pend_clr;
  logic [NUM_OBST-1:0] w_merge;
  logic [1:0]          w_merge_cnt;
  logic [4:0]          w_merged_sum;
  logic [1:0]          w_code;
  logic                w_accept;

  assign w_code   = r_code;
  assign w_accept = r_valid && event_ready;

  for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_obst
    hit_cooldown_timer #(
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
      .CNT_W          (CNT_W)
    ) u_cooldown (
      .clk   (clk),
      .resetN(resetN),
      .i_load(startOfFrame && r_latch[gi]),
      .i_tick(startOfFrame),
      .o_zero(w_cd_zero[gi])
    );
    assign w_accept_mask[gi] = w_accept && (w_code == 2'(gi + 1));
  end

  assign w_hit_now  = collision & {NUM_OBST{game_enable}} & w_cd_zero;
  assign w_pend_clr = r_pending & ~w_accept_mask;
  // A hit already waiting (and not leaving this cycle) absorbs the new one.
  assign w_merge    = startOfFrame ? (w_pend_clr & r_latch) : '0;

  always_comb begin
    w_merge_cnt = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      w_merge_cnt = w_merge_cnt + 2'(w_merge[i]);
    end
  end

  assign w_merged_sum = {1'b0, r_merged} + 5'(w_merge_cnt);

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state   <= COLLECT;
      r_code    <= NONE;
      r_valid   <= 1'b0;
      r_latch   <= '0;
      r_pending <= '0;
      r_total   <= '0;
      r_merged  <= '0;
    end else begin
      r_pending <= w_pend_clr | (startOfFrame ? r_latch : '0);
      r_latch   <= (startOfFrame ? '0 : r_latch) | w_hit_now;
      r_merged  <= (w_merged_sum > 5'd15) ? 4'hF : w_merged_sum[3:0];
      if (w_accept) r_total <= r_total + 8'd1;

      case (r_state)
        COLLECT: begin
          if (r_pending != '0) begin
            r_state <= EMIT;
            r_code  <= lowest_code(r_pending);
            r_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (event_ready) begin
            if (w_pend_clr != '0) begin
              r_code <= lowest_code(w_pend_clr);
            end else begin
              r_state <= COLLECT;
              r_code  <= NONE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= COLLECT;
          r_code  <= NONE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign obstacle_num = r_code;
  assign event_valid  = r_valid;
  assign total_hits   = r_total;
  assign merged_hits  = r_merged;

`ifdef HIT_SOUND_EN
  logic r_sound;
  always_ff @(posedge clk) begin
    if (resetN) r_sound <= 1'b0;
    else        r_sound <= w_accept;
  end
  assign sound_trigger = r_sound;
`else
  assign sound_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_hit_event_encoder.sv
// Self-checking bench: two encoders (cooldown 8 and 0) share stimulus and are
// compared every cycle with a frame-level reference model plus directed checks.
module tb_hit_event_encoder;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       game_enable = 1'b0;
  logic [2:0] collision = 3'b000;
  logic       event_ready = 1'b0;

  logic [1:0] num[2];
  logic       valid[2];
  logic [7:0] total[2];
  logic [3:0] merged[2];
  logic       snd[2];

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  always #5 clk = ~clk;

  hit_event_encoder #(.COOLDOWN_FRAMES(8), .CNT_W(4)) u_dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .game_enable(game_enable),
    .collision(collision), .event_ready(event_ready), .obstacle_num(num[0]),
    .event_valid(valid[0]), .total_hits(total[0]), .merged_hits(merged[0]),
    .sound_trigger(snd[0]));

  hit_event_encoder #(.COOLDOWN_FRAMES(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .game_enable(game_enable),
    .collision(collision), .event_ready(event_ready), .obstacle_num(num[1]),
    .event_valid(valid[1]), .total_hits(total[1]), .merged_hits(merged[1]),
    .sound_trigger(snd[1]));

  // Reference model: one record per DUT instance
  int       m_cdlen[2] = '{8, 0};
  int       m_cd[2][3];
  bit [2:0] m_latch[2];
  bit [2:0] m_pend[2];
  bit       m_valid[2];
  int       m_code[2];
  int       m_total[2];
  int       m_merged[2];
  bit       m_snd[2];

  function automatic int low_idx(input bit [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int k);
    bit       acc;
    bit [2:0] clr;
    bit [2:0] old_pend;
    if (resetN) begin
      for (int i = 0; i < 3; i++) m_cd[k][i] = 0;
      m_latch[k] = 0; m_pend[k] = 0; m_valid[k] = 0; m_code[k] = 0;
      m_total[k] = 0; m_merged[k] = 0; m_snd[k] = 0;
      return;
    end
    acc      = m_valid[k] && event_ready;
    old_pend = m_pend[k];
    clr      = old_pend;
    if (acc) clr[m_code[k]-1] = 1'b0;
    m_pend[k] = clr;
    for (int i = 0; i < 3; i++) begin
      bit hit_now;
      hit_now = collision[i] && game_enable && (m_cd[k][i] == 0);
      if (startOfFrame) begin
        if (m_latch[k][i]) begin
          if (clr[i] && m_merged[k] < 15) m_merged[k]++;
          m_pend[k][i] = 1'b1;
          m_cd[k][i] = m_cdlen[k];
        end else if (m_cd[k][i] > 0) begin
          m_cd[k][i]--;
        end
        m_latch[k][i] = hit_now;
      end else begin
        m_latch[k][i] = m_latch[k][i] | hit_now;
      end
    end
    if (!m_valid[k]) begin
      if (old_pend != 0) begin
        m_valid[k] = 1'b1;
        m_code[k]  = low_idx(old_pend) + 1;
      end
    end else if (acc) begin
      if (clr != 0) m_code[k] = low_idx(clr) + 1;
      else begin
        m_valid[k] = 1'b0;
        m_code[k]  = 0;
      end
    end
    if (acc) m_total[k] = (m_total[k] + 1) % 256;
    m_snd[k] = acc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int k);
    bit exp_snd;
`ifdef HIT_SOUND_EN
    exp_snd = m_snd[k];
`else
    exp_snd = 1'b0;
`endif
    chk($sformatf("model_num[%0d]", k), 32'(num[k]), 32'(m_code[k]));
    chk($sformatf("model_valid[%0d]", k), 32'(valid[k]), 32'(m_valid[k]));
    chk($sformatf("model_total[%0d]", k), 32'(total[k]), 32'(m_total[k]));
    chk($sformatf("model_merged[%0d]", k), 32'(merged[k]), 32'(m_merged[k]));
    chk($sformatf("model_sound[%0d]", k), 32'(snd[k]), 32'(exp_snd));
  endtask

  task automatic tick();
    bit acc_a;
    acc_a = valid[0] && event_ready;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (verbose && acc_a && !resetN) $display("event A accepted, total_hits=%0d", total[0]);
    check_model(0);
    check_model(1);
  endtask

  task automatic do_reset();
    resetN = 1'b1; startOfFrame = 1'b0; collision = 3'b000; event_ready = 1'b0;
    tick(); tick();
    resetN = 1'b0; game_enable = 1'b1;
  endtask

  typedef struct {
    bit       rst, sof, en;
    bit [2:0] coll;
    bit       rdy;
    bit [1:0] exp_num;
    bit       exp_valid;
    int       exp_total;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit rst, bit sof, bit [2:0] coll, bit [1:0] n, bit v, int t);
    vec_t r;
    r.rst = rst; r.sof = sof; r.en = 1'b1; r.coll = coll; r.rdy = 1'b1;
    r.exp_num = n; r.exp_valid = v; r.exp_total = t;
    return r;
  endfunction

  initial begin
    int ev;
    int evf[2];
    int snd_cnt;

    for (int i = 0; i < 5; i++) vecs[i] = mk(0, 0, 3'b001, 2'd0, 0, 0);
    vecs[5]  = mk(0, 1, 3'b000, 2'd0, 0, 0);
    vecs[6]  = mk(0, 0, 3'b000, 2'd1, 1, 0);
    vecs[7]  = mk(0, 0, 3'b000, 2'd0, 0, 1);
    vecs[8]  = mk(0, 0, 3'b000, 2'd0, 0, 1);
    vecs[9]  = mk(1, 0, 3'b000, 2'd0, 0, 0);
    vecs[10] = mk(0, 0, 3'b101, 2'd0, 0, 0);
    vecs[11] = mk(0, 1, 3'b000, 2'd0, 0, 0);
    vecs[12] = mk(0, 0, 3'b000, 2'd1, 1, 0);
    vecs[13] = mk(0, 0, 3'b000, 2'd3, 1, 1);
    vecs[14] = mk(0, 0, 3'b000, 2'd0, 0, 2);
    vecs[15] = mk(0, 0, 3'b000, 2'd0, 0, 2);

    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", 32'(valid[k]), 32'd0);
      chk("reset_num", 32'(num[k]), 32'd0);
      chk("reset_total", 32'(total[k]), 32'd0);
    end

    // Single hit, then two simultaneous hits (table-driven)
    for (int v = 0; v < 16; v++) begin
      resetN = vecs[v].rst; startOfFrame = vecs[v].sof; game_enable = vecs[v].en;
      collision = vecs[v].coll; event_ready = vecs[v].rdy;
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_num", v), 32'(num[k]), 32'(vecs[v].exp_num));
        chk($sformatf("vec%0d_valid", v), 32'(valid[k]), 32'(vecs[v].exp_valid));
        chk($sformatf("vec%0d_total", v), 32'(total[k]), 32'(vecs[v].exp_total));
      end
    end

    // Cooldown: obstacle 2 every frame for 12 frames
    do_reset();
    event_ready = 1'b1;
    ev = 0; evf[0] = 0; evf[1] = 0;
    for (int f = 1; f <= 12; f++) begin
      collision = 3'b010; tick(); tick();
      collision = 3'b000; tick();
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        if (valid[0] && num[0] == 2'd2) begin
          if (ev < 2) evf[ev] = f;
          ev++;
        end
      end
    end
    chk("cooldown_event_count", 32'(ev), 32'd2);
    chk("cooldown_first_frame", 32'(evf[0]), 32'd1);
    chk("cooldown_second_frame", 32'(evf[1]), 32'd10);
    chk("cooldown_total_a", 32'(total[0]), 32'd2);
    chk("no_cooldown_total_b", 32'(total[1]), 32'd12);

    // Back-pressure with a merged re-hit on the zero-cooldown instance
    do_reset();
    collision = 3'b010; tick();
    collision = 3'b000; startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick();
    chk("stall_first_valid", 32'(valid[1]), 32'd1);
    for (int s = 0; s < 6; s++) begin
      collision    = (s == 1) ? 3'b010 : 3'b000;
      startOfFrame = (s == 2);
      tick();
      chk($sformatf("stall%0d_valid", s), 32'(valid[1]), 32'd1);
      chk($sformatf("stall%0d_num", s), 32'(num[1]), 32'd2);
    end
    startOfFrame = 1'b0; event_ready = 1'b1; tick();
    chk("stall_release_valid", 32'(valid[1]), 32'd0);
    chk("stall_total_b", 32'(total[1]), 32'd1);
    chk("stall_merged_b", 32'(merged[1]), 32'd1);
    chk("stall_merged_a", 32'(merged[0]), 32'd0);

    // Reset while an event is presented
    do_reset();
    collision = 3'b001; tick();
    collision = 3'b000; startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick();
    chk("pre_reset_num", 32'(num[0]), 32'd1);
    resetN = 1'b1; tick();
    chk("midreset_valid", 32'(valid[0]), 32'd0);
    chk("midreset_num", 32'(num[0]), 32'd0);
    chk("midreset_total", 32'(total[0]), 32'd0);
    resetN = 1'b0; event_ready = 1'b1;
    ev = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (valid[0]) ev++;
    end
    chk("post_reset_no_event", 32'(ev), 32'd0);

    // Sound pulses for three accepted events
    do_reset();
    event_ready = 1'b1; collision = 3'b111; tick();
    collision = 3'b000; startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0;
    snd_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (snd[0]) snd_cnt++;
    end
`ifdef HIT_SOUND_EN
    chk("sound_pulses", 32'(snd_cnt), 32'd3);
`else
    chk("sound_pulses", 32'(snd_cnt), 32'd0);
`endif
    chk("sound_total", 32'(total[0]), 32'd3);

    // Randomised traffic against the model
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      resetN       = ($urandom_range(0, 299) == 0);
      startOfFrame = ($urandom_range(0, 7) == 0);
      game_enable  = ($urandom_range(0, 9) != 0);
      collision    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      event_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hit_event_encoder.md
Name: hit_event_encoder

Overview:
- Producer side of the obstacle-hit interface: turns per-pixel collision flags from the drawing pipeline into clean, single-cycle obstacle hit codes (obstacle_num).
- Score counters consume these codes and increment once per cycle the code matches.
- Latches collisions during a frame and applies a per-obstacle cooldown so one physical hit scores once.
- Serialises simultaneous hits into one code per cycle, with a valid/ready hold-off.

Parameters:
- COOLDOWN_FRAMES, 8: frames an obstacle is ignored after a hit is accepted. 0 disables cooldown.
- CNT_W, 4: cooldown counter width. Must hold COOLDOWN_FRAMES.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset. Sampled on rising clk; 1 = reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- game_enable  in  1  collisions ignored while 0.
- collision  in  3  bit i = ball pixel coincides with obstacle i+1 this cycle.
- event_ready  in  1  consumer accepts the current code.
- obstacle_num  out  2  00 none; 01/10/11 = obstacle 1/2/3 hit. Registered.
- event_valid  out  1  obstacle_num is non-zero and presented. Registered.
- total_hits  out  8  accepted-hit count; wraps 255 -> 0.
- merged_hits  out  4  hits lost to merging; saturates at 15.
- sound_trigger  out  1  see Optional Feature.

Behaviour:
- Reset (resetN=1 at a clk edge): next cycle all of the following are 0 — outputs, latches, pending mask, cooldowns, counters; state = COLLECT. Applies mid-EMIT as well: the pending event is discarded.
- Latch: hit_latch[i] <= 1 when collision[i] && game_enable && cooldown[i]==0. The latch is sticky until the snapshot.
- Snapshot on startOfFrame:
  - pending <= pending | hit_latch.
  - hit_latch cleared. A collision in the same cycle sets the new latch, not the snapshot.
  - cooldown[i] <= COOLDOWN_FRAMES for snapshotted bits.
  - Other non-zero cooldowns decrement by 1, floor 0.
  - merged_hits increments once per bit already set in pending and in hit_latch.
- States:
  - COLLECT: event_valid=0, obstacle_num=00. Go to EMIT the cycle after a snapshot leaves pending non-zero.
  - EMIT: present the lowest-index pending bit (obstacle_num = i+1, event_valid=1). On event_ready=1 at a clk edge:
    - clear that bit;
    - total_hits++;
    - next cycle present the next pending bit, or return to COLLECT with outputs 00/0 when pending is empty.
  - With event_ready held 1, events go out on consecutive cycles, each code exactly 1 cycle.
  - With event_ready=0, the code is held unchanged. Snapshots during EMIT merge into pending.
- Latency: startOfFrame edge → first event_valid=1 two cycles later. Cycle 1: snapshot. Cycle 2: registered output.
- game_enable falling: stops new latching only. Pending events still drain.

Optional Feature:
- Macro: HIT_SOUND_EN.
- Defined: sound_trigger pulses 1 for exactly one cycle on each accepted event (event_valid && event_ready).
- Undefined: sound_trigger tied 0; no extra logic.

Decomposition:
- Package hit_pkg holds:
  - obst_code_t (NONE=2'b00, OBST1=2'b01, OBST2=2'b10, OBST3=2'b11);
  - NUM_OBST=3;
  - state enum enc_state_t {COLLECT, EMIT}.
- Sub-module hit_cooldown_timer, one per obstacle (load, frame-tick decrement, zero flag), instantiated NUM_OBST times.

Test Plan:
- Reset, then collision=3'b001 for 5 cycles mid-frame, then startOfFrame, event_ready=1 → obstacle_num=01, event_valid=1 for exactly 1 cycle, 2 cycles after startOfFrame; total_hits=1.
- collision=3'b101 in one frame, event_ready=1 → codes 01 then 11 on consecutive cycles, then 00; total_hits=2.
- Cooldown: obstacle 2 collides every frame for 12 frames, COOLDOWN_FRAMES=8 → events at frame 1 and frame 10 only; total_hits=2.
- Back-pressure: event_ready=0 for 6 cycles with code 10 pending → code and valid held 6 cycles; releases on ready=1. A second snapshot of obstacle 2 during the stall (COOLDOWN_FRAMES=0) → merged_hits=1.
- resetN=1 asserted while EMIT presents 01 → next cycle event_valid=0, obstacle_num=00, total_hits=0, no event after deassertion.
- With HIT_SOUND_EN: 3 accepted events → 3 single-cycle sound_trigger pulses. Without it: sound_trigger stays 0.
